sensor_packet_framer: RTL and testbench
=======================================

# sensor_packet_framer

Buffers the 102-bit sensor iteration records produced by the triad manager and frames each into a byte-oriented packet for the MCU link transmitter. Sits directly downstream of the triad manager in the 72 MHz domain. Decouples bursty `data_avl` strobes from the slower byte-level link with a small FIFO and a valid/ready byte handshake.

## Interface

Parameters:
- `DEPTH`, 4, FIFO depth in records; power of two, 2..16.
- `HEADER`, 8'hA5, packet start byte.

Ports:
- `clk_72MHz`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_avl`  in  1  one-cycle strobe; `sensor_iterations` is valid this cycle.
- `sensor_iterations`  in  102  record from the triad manager.
- `byte_out`  out  8  current packet byte.
- `byte_valid`  out  1  `byte_out` holds a byte to transfer.
- `byte_ready`  in  1  transmitter accepts `byte_out` this cycle.
- `fifo_level`  out  $clog2(DEPTH)+1  records stored, excluding the record being sent.
- `drop_count`  out  8  records discarded on overflow; saturates at 255.
- `busy`  out  1  high while a packet is being emitted.

## Operation

- Record padding: `{2'b00, sensor_iterations}` gives 104 bits, which is 13 payload bytes. Byte 0 is bits [103:96] and byte 12 is bits [7:0]. The payload is sent MSB byte first.
- Packet format: `HEADER`, then payload bytes 0..12, then an optional checksum (see Configuration).
- FIFO write on `data_avl`:
  - The write is accepted if `fifo_level < DEPTH`, or if a pop occurs in the same cycle.
  - Otherwise the record is dropped and `drop_count` increments, saturating at 255.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into a 104-bit shift register, present `HEADER`, go to HEADER. `busy` goes high.
  - HEADER: on transfer, present payload byte 0 and go to PAYLOAD with `idx=0`.
  - PAYLOAD: on transfer, if `idx<12`, shift, present the next byte and increment `idx`.
    - If `idx==12` with `CHECKSUM_EN`, present the checksum and go to CHECKSUM.
    - If `idx==12` without it, go to IDLE.
  - CHECKSUM: on transfer, go to IDLE.
- Handshake:
  - A transfer occurs on a rising edge where `byte_valid && byte_ready`.
  - Once `byte_valid` rises, `byte_out` is held stable until the transfer.
  - `byte_valid` never drops without a transfer, except on `reset`.
  - `byte_ready` without `byte_valid` has no effect.
- Back-to-back packets: on the transfer of the last byte, if the FIFO is non-empty, the FSM pops immediately and presents `HEADER` the next cycle. It may instead pass through IDLE for one cycle; both are legal, and the bench must accept either.
- Reset (also mid-packet):
  - FIFO emptied, FSM to IDLE, `idx` cleared.
  - `byte_valid=0`, `byte_out=8'h00`, `busy=0`, `fifo_level=0`, `drop_count=0`.
  - A partial packet is abandoned with no trailer.

## Timing

- All outputs are registered.
- Latency, empty FIFO and IDLE FSM: `data_avl` sampled at edge N gives `fifo_level=1` after N. The FSM pops at edge N+1, so `byte_valid=1` with `HEADER` after edge N+1 and `fifo_level` returns to 0.
- Throughput: one byte per cycle while `byte_ready` is held high. A packet takes 14 cycles, or 15 with `CHECKSUM_EN`.
- Simultaneous write and pop with the FIFO full: the write is accepted and `fifo_level` stays at DEPTH.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `fifo_level` is derived from a separate occupancy counter, so full and empty are unambiguous.
- `drop_count` at 255 stays at 255.
- `data_avl` during reset is ignored.

## Configuration

- `PACKET_CHECKSUM_EN`
  - Defined: a 15th byte equal to the XOR of the 13 payload bytes is appended; the header is excluded.
  - Undefined: packets are 14 bytes, there is no CHECKSUM state, and the XOR logic is not synthesised.

## Test plan

- Single record, `sensor_iterations = 102'h2_0123_4567_89AB_CDEF_0011_2233`, `byte_ready=1`:
  - Expect A5, 02 01 23 45 67 89 AB CD EF 00 11 22 33.
  - With the macro, the checksum byte follows; its value is the XOR of those 13 bytes, computed by the reference model.
- Backpressure: `byte_ready` toggles 1-0-0-1 pseudo-randomly. Expect `byte_out` unchanged while `byte_valid && !byte_ready`, and the byte sequence identical to the first test.
- Overflow, DEPTH=4, `byte_ready=0`: 7 `data_avl` strobes. The first record goes to the shifter and 4 fill the FIFO. Expect `fifo_level=4` and `drop_count=2`. Then release `byte_ready`: exactly 5 packets emerge, in order.
- Saturation: 300 dropped strobes with the FIFO full. Expect `drop_count=255`.
- Reset mid-packet: assert `reset` for 1 cycle after payload byte 5. Expect `byte_valid=0` and `fifo_level=0` the next cycle. A new record then yields a complete packet starting with A5.
- Same-cycle write and pop with the FIFO full: `data_avl` on the pop edge. Expect no drop and `fifo_level=DEPTH`.

Source files
------------

// File: rtl/sensor_packet_framer.sv
`default_nettype none
// ============================================================================
// Module   : sensor_packet_framer
// Purpose  : Buffers 102-bit sensor iteration records from the triad manager
//            in a small FIFO. Each record is framed as one byte packet for the
//            MCU link: HEADER, then 13 payload bytes (MSB byte first), then an
//            optional XOR checksum byte.
// Option   : PACKET_CHECKSUM_EN - when defined, a 15th byte is appended. It is
//            the XOR of the 13 payload bytes; the header is not included.
// Ports    : clk_72MHz          system clock, rising edge
//            reset              synchronous, active-high
//            data_avl           one-cycle strobe qualifying sensor_iterations
//            sensor_iterations  [101:0] record to buffer
//            byte_out           [7:0] current packet byte (registered)
//            byte_valid         byte_out holds a byte to transfer
//            byte_ready         transmitter accepts byte_out this cycle
//            fifo_level         records queued, excluding the one being sent
//            drop_count         records lost to overflow, saturating at 255
//            busy               high while a packet is being emitted
// Revision : 1.0 - initial release
// ============================================================================
module sensor_packet_framer #(
  parameter int         DEPTH  = 4,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic                     clk_72MHz,
  input  logic                     reset,
  input  logic                     data_avl,
  input  logic [101:0]             sensor_iterations,
  output logic [7:0]               byte_out,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               drop_count,
  output logic                     busy
);

  localparam int               PTR_W      = $clog2(DEPTH);
  localparam int               LVL_W      = PTR_W + 1;
  localparam logic [LVL_W-1:0] c_FULL     = LVL_W'(DEPTH);
  localparam logic [3:0]       c_LAST_IDX = 4'd12;

`ifdef PACKET_CHECKSUM_EN
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HEADER   = 2'd1,
    S_PAYLOAD  = 2'd2,
    S_CHECKSUM = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HEADER   = 2'd1,
    S_PAYLOAD  = 2'd2
  } state_t;
`endif

  // FIFO storage and bookkeeping. The occupancy counter is kept separately
  // from the pointers so that full and empty cannot be confused.
  logic [101:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_count;
  logic [7:0]         r_drop;

  // Framer state
  state_t             r_state,  w_state_nxt;
  logic [3:0]         r_idx,    w_idx_nxt;
  logic [103:0]       r_shreg,  w_shreg_nxt;
  logic [7:0]         r_byte,   w_byte_nxt;
  logic               r_valid,  w_valid_nxt;
  logic               r_busy,   w_busy_nxt;
`ifdef PACKET_CHECKSUM_EN
  logic [7:0]         r_csum,   w_csum_nxt;
`endif

  logic               w_xfer;
  logic               w_pop;
  logic               w_push;
  logic               w_done;
  logic               w_fifo_empty;
  logic [7:0]         w_head;
  logic [103:0]       w_shift;

  assign w_xfer       = r_valid & byte_ready;
  assign w_fifo_empty = (r_count == '0);
  assign w_head       = r_shreg[103:96];
  assign w_shift      = {r_shreg[95:0], 8'h00};
  // A full FIFO still accepts a record when the head leaves on the same edge.
  assign w_push       = data_avl & ((r_count != c_FULL) | w_pop);

  // Next-state and output logic. The shift register always holds the next
  // payload byte in its top 8 bits, so each transfer presents w_head.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_shreg_nxt = r_shreg;
    w_byte_nxt  = r_byte;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
`ifdef PACKET_CHECKSUM_EN
    w_csum_nxt  = r_csum;
`endif
    w_pop       = 1'b0;
    w_done      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_pop = ~w_fifo_empty;
      end
      S_HEADER: begin
        if (w_xfer) begin
          w_byte_nxt  = w_head;
          w_shreg_nxt = w_shift;
`ifdef PACKET_CHECKSUM_EN
          w_csum_nxt  = w_head;
`endif
          w_idx_nxt   = 4'd0;
          w_state_nxt = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (w_xfer) begin
          if (r_idx != c_LAST_IDX) begin
            w_byte_nxt  = w_head;
            w_shreg_nxt = w_shift;
`ifdef PACKET_CHECKSUM_EN
            w_csum_nxt  = r_csum ^ w_head;
`endif
            w_idx_nxt   = r_idx + 4'd1;
          end else begin
`ifdef PACKET_CHECKSUM_EN
            w_byte_nxt  = r_csum;
            w_state_nxt = S_CHECKSUM;
`else
            w_done      = 1'b1;
`endif
          end
        end
      end
`ifdef PACKET_CHECKSUM_EN
      S_CHECKSUM: begin
        if (w_xfer) w_done = 1'b1;
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Last byte accepted: fall back to idle unless another record is queued.
    if (w_done) begin
      w_state_nxt = S_IDLE;
      w_valid_nxt = 1'b0;
      w_busy_nxt  = 1'b0;
      w_byte_nxt  = 8'h00;
      w_pop       = ~w_fifo_empty;
    end

    // Pop the FIFO head into the shifter and present the header next cycle.
    if (w_pop) begin
      w_shreg_nxt = {2'b00, r_mem[r_rd_ptr]};
      w_byte_nxt  = HEADER;
      w_valid_nxt = 1'b1;
      w_busy_nxt  = 1'b1;
      w_idx_nxt   = 4'd0;
      w_state_nxt = S_HEADER;
    end
  end

  always_ff @(posedge clk_72MHz) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 8'h00;
      r_state  <= S_IDLE;
      r_idx    <= 4'd0;
      r_shreg  <= '0;
      r_byte   <= 8'h00;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
`ifdef PACKET_CHECKSUM_EN
      r_csum   <= 8'h00;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_shreg <= w_shreg_nxt;
      r_byte  <= w_byte_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
`ifdef PACKET_CHECKSUM_EN
      r_csum  <= w_csum_nxt;
`endif
      if (w_push) begin
        r_mem[r_wr_ptr] <= sensor_iterations;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LVL_W'(1);
        2'b01:   r_count <= r_count - LVL_W'(1);
        default: r_count <= r_count;
      endcase
      if (data_avl && !w_push && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'd1;
      end
    end
  end

  assign byte_out   = r_byte;
  assign byte_valid = r_valid;
  assign busy       = r_busy;
  assign fifo_level = r_count;
  assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_sensor_packet_framer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sensor_packet_framer
// Purpose  : Directed self-checking bench for sensor_packet_framer. Honours
//            PACKET_CHECKSUM_EN for the expected packet length.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_packet_framer;

  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef PACKET_CHECKSUM_EN
  localparam int PKT_LEN = 15;
`else
  localparam int PKT_LEN = 14;
`endif

  logic              clk_72MHz;
  logic              reset;
  logic              data_avl;
  logic [101:0]      sensor_iterations;
  logic [7:0]        byte_out;
  logic              byte_valid;
  logic              byte_ready;
  logic [LVL_W-1:0]  fifo_level;
  logic [7:0]        drop_count;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   got [15];
  int           got_n;
  int           got_hold_errs;
  logic [7:0]   exp_pkt [15];
  logic [101:0] recs [8];
  logic [15:0]  bp_pat = 16'b1001_0110_1001_1100;

  // Hand-computed bytes for record 102'h2_0123_4567_89AB_CDEF_0011_2233;
  // the last entry is the XOR of the 13 payload bytes.
  logic [7:0] single_tab [15] = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h45, 8'h67,
                                  8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h11,
                                  8'h22, 8'h33, 8'h02};
  logic [101:0] c_REC = 102'h2_0123_4567_89AB_CDEF_0011_2233;

  sensor_packet_framer #(.DEPTH(DEPTH), .HEADER(8'hA5)) dut (
    .clk_72MHz         (clk_72MHz),
    .reset             (reset),
    .data_avl          (data_avl),
    .sensor_iterations (sensor_iterations),
    .byte_out          (byte_out),
    .byte_valid        (byte_valid),
    .byte_ready        (byte_ready),
    .fifo_level        (fifo_level),
    .drop_count        (drop_count),
    .busy              (busy)
  );

  initial clk_72MHz = 1'b0;
  always #5 clk_72MHz = ~clk_72MHz;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk_72MHz);
    #1;
  endtask

  task automatic do_reset;
    reset      = 1'b1;
    data_avl   = 1'b0;
    byte_ready = 1'b0;
    tick();
    reset      = 1'b0;
  endtask

  task automatic push(input logic [101:0] rec);
    data_avl          = 1'b1;
    sensor_iterations = rec;
    tick();
    data_avl          = 1'b0;
  endtask

  // Reference packet: header, padded record MSB byte first, XOR of payload.
  task automatic build_exp(input logic [101:0] rec);
    logic [103:0] padded;
    logic [7:0]   x;
    padded = {2'b00, rec};
    x = 8'h00;
    exp_pkt[0] = 8'hA5;
    for (int i = 0; i < 13; i++) begin
      exp_pkt[i+1] = padded[103-8*i -: 8];
      x = x ^ padded[103-8*i -: 8];
    end
    exp_pkt[14] = x;
  endtask

  // Collects one packet's worth of transferred bytes. With bp set, ready
  // follows a fixed irregular pattern and holds of byte_out are tallied.
  task automatic get_packet(input bit bp);
    logic [7:0] held;
    bit         holding;
    got_n = 0;
    got_hold_errs = 0;
    holding = 1'b0;
    held = 8'h00;
    for (int cyc = 0; cyc < 400 && got_n < PKT_LEN; cyc++) begin
      if (holding && (!byte_valid || byte_out !== held)) got_hold_errs++;
      byte_ready = bp ? bp_pat[cyc % 16] : 1'b1;
      if (byte_valid && byte_ready) begin
        got[got_n] = byte_out;
        got_n++;
        holding = 1'b0;
      end else if (byte_valid) begin
        holding = 1'b1;
        held = byte_out;
      end else begin
        holding = 1'b0;
      end
      tick();
    end
    byte_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    data_avl = 1'b1;
    sensor_iterations = c_REC;
    tick();
    tick();
    reset = 1'b0;
    data_avl = 1'b0;
    n_checks++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", byte_valid); end
    n_checks++; if (byte_out !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h want 00", byte_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    tick();
    n_checks++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ignore_avl: got valid %b want 0", byte_valid); end
  endtask

  task automatic test_single;
    do_reset();
    push(c_REC);
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL lat_level1: got %0d want 1", fifo_level); end
    n_checks++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL lat_valid0: got %b want 0", byte_valid); end
    tick();
    n_checks++; if (byte_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid1: got %b want 1", byte_valid); end
    n_checks++; if (byte_out !== 8'hA5) begin n_fail++; $display("FAIL lat_header: got %h want a5", byte_out); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL lat_level0: got %0d want 0", fifo_level); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lat_busy: got %b want 1", busy); end
    get_packet(1'b0);
    n_checks++; if (got_n !== PKT_LEN) begin n_fail++; $display("FAIL single_len: got %0d want %0d", got_n, PKT_LEN); end
    for (int i = 0; i < PKT_LEN; i++) begin
      n_checks++; if (got[i] !== single_tab[i]) begin n_fail++; $display("FAIL single_byte%0d: got %h want %h", i, got[i], single_tab[i]); end
    end
    n_checks++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL single_end_valid: got %b want 0", byte_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_backpressure;
    do_reset();
    push(c_REC);
    get_packet(1'b1);
    n_checks++; if (got_n !== PKT_LEN) begin n_fail++; $display("FAIL bp_len: got %0d want %0d", got_n, PKT_LEN); end
    n_checks++; if (got_hold_errs !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles want 0", got_hold_errs); end
    for (int i = 0; i < PKT_LEN; i++) begin
      n_checks++; if (got[i] !== single_tab[i]) begin n_fail++; $display("FAIL bp_byte%0d: got %h want %h", i, got[i], single_tab[i]); end
    end
  endtask

  task automatic test_overflow;
    do_reset();
    for (int k = 0; k < 7; k++) push(recs[k]);
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
    n_checks++; if (drop_count !== 8'd2) begin n_fail++; $display("FAIL ovf_drop: got %0d want 2", drop_count); end
    for (int p = 0; p < 5; p++) begin
      build_exp(recs[p]);
      get_packet(1'b0);
      n_checks++; if (got_n !== PKT_LEN) begin n_fail++; $display("FAIL ovf_len_p%0d: got %0d want %0d", p, got_n, PKT_LEN); end
      for (int i = 0; i < PKT_LEN; i++) begin
        n_checks++; if (got[i] !== exp_pkt[i]) begin n_fail++; $display("FAIL ovf_p%0d_byte%0d: got %h want %h", p, i, got[i], exp_pkt[i]); end
      end
    end
    tick();
    n_checks++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_no_sixth: got valid %b want 0", byte_valid); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL ovf_drained: got %0d want 0", fifo_level); end
  endtask

  task automatic test_saturation;
    do_reset();
    for (int k = 0; k < 5; k++) push(recs[k]);
    sensor_iterations = recs[5];
    for (int k = 0; k < 300; k++) begin
      data_avl = 1'b1;
      tick();
      if (k == 253) begin
        n_checks++; if (drop_count !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d want 254", drop_count); end
      end
      if (k == 254) begin
        n_checks++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d want 255", drop_count); end
      end
    end
    data_avl = 1'b0;
    n_checks++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d want 255", drop_count); end
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL sat_level: got %0d want 4", fifo_level); end
  endtask

  task automatic test_reset_mid_packet;
    int xfers;
    do_reset();
    push(recs[0]);
    push(recs[1]);
    push(recs[2]);
    n_checks++; if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL mid_pre_level: got %0d want 2", fifo_level); end
    build_exp(recs[0]);
    byte_ready = 1'b1;
    xfers = 0;
    for (int cyc = 0; cyc < 100 && xfers < 7; cyc++) begin
      if (byte_valid) xfers++;
      tick();
    end
    n_checks++; if (byte_out !== exp_pkt[7]) begin n_fail++; $display("FAIL mid_byte6: got %h want %h", byte_out, exp_pkt[7]); end
    reset = 1'b1;
    byte_ready = 1'b0;
    tick();
    reset = 1'b0;
    n_checks++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", byte_valid); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL mid_level: got %0d want 0", fifo_level); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_checks++; if (byte_out !== 8'h00) begin n_fail++; $display("FAIL mid_byte: got %h want 00", byte_out); end
    push(recs[6]);
    build_exp(recs[6]);
    get_packet(1'b0);
    n_checks++; if (got_n !== PKT_LEN) begin n_fail++; $display("FAIL mid_new_len: got %0d want %0d", got_n, PKT_LEN); end
    for (int i = 0; i < PKT_LEN; i++) begin
      n_checks++; if (got[i] !== exp_pkt[i]) begin n_fail++; $display("FAIL mid_new_byte%0d: got %h want %h", i, got[i], exp_pkt[i]); end
    end
    tick();
    n_checks++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale: got valid %b want 0", byte_valid); end
  endtask

  task automatic test_full_pop;
    int xfers;
    int order [5];
    order = '{1, 2, 3, 4, 7};
    do_reset();
    for (int k = 0; k < 5; k++) push(recs[k]);
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL fp_pre_level: got %0d want 4", fifo_level); end
    byte_ready = 1'b1;
    xfers = 0;
    for (int cyc = 0; cyc < 100 && xfers < PKT_LEN; cyc++) begin
      if (byte_valid) begin
        if (xfers == PKT_LEN - 1) begin
          data_avl = 1'b1;
          sensor_iterations = recs[7];
        end
        xfers++;
      end
      tick();
      data_avl = 1'b0;
    end
    byte_ready = 1'b0;
    if (byte_valid) begin
      // Next header issued straight away: the strobe landed on the pop edge.
      n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL fp_level: got %0d want 4", fifo_level); end
      n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL fp_drop: got %0d want 0", drop_count); end
    end else begin
      // Idle cycle taken: that strobe was a genuine overflow; retry on the pop edge.
      data_avl = 1'b1;
      sensor_iterations = recs[7];
      tick();
      data_avl = 1'b0;
      n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL fp_level_idle: got %0d want 4", fifo_level); end
      n_checks++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL fp_drop_idle: got %0d want 1", drop_count); end
    end
    for (int p = 0; p < 5; p++) begin
      build_exp(recs[order[p]]);
      get_packet(1'b0);
      n_checks++; if (got_n !== PKT_LEN) begin n_fail++; $display("FAIL fp_len_p%0d: got %0d want %0d", p, got_n, PKT_LEN); end
      for (int i = 0; i < PKT_LEN; i++) begin
        n_checks++; if (got[i] !== exp_pkt[i]) begin n_fail++; $display("FAIL fp_p%0d_byte%0d: got %h want %h", p, i, got[i], exp_pkt[i]); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    data_avl = 1'b0;
    byte_ready = 1'b0;
    sensor_iterations = '0;
    for (int k = 0; k < 8; k++) begin
      recs[k] = {6'(k + 1), 32'hC0DE_0000 + 32'(k), 32'h1234_5678 ^ 32'(k * 3),
                 32'h0101_0101 * 32'(k + 1)};
    end
    tick();
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_saturation();
    test_reset_mid_packet();
    test_full_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
